// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage byte-addressed big-endian data memory with wait states; optional DMEM_ERR_EN
module data_mem_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH       = 256
) (
    input  logic        clk,
    input  logic        R,
    input  logic        en,
    input  logic        rw,
    input  logic        size,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall
`ifdef DMEM_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
`ifdef DMEM_ERR_EN
    logic        err_q, err_d;
`endif

    logic [7:0]  mem_q [DEPTH];
    logic        mem_we;
    logic        misaligned;
    logic [7:0]  base_addr;
    logic [7:0]  a0, a1, a2, a3;

    // Effective address of the latched request; misaligned words snap to the aligned word when checking is on
    always_comb begin
        misaligned = 1'b0;
        base_addr  = addr_q;
`ifdef DMEM_ERR_EN
        misaligned = size_q && (addr_q[1:0] != 2'b00);
        if (misaligned) begin
            base_addr = {addr_q[7:2], 2'b00};
        end
`endif
        a0 = base_addr;
        a1 = base_addr + 8'd1;
        a2 = base_addr + 8'd2;
        a3 = base_addr + 8'd3;
    end

    // Next-state and datapath: accept in IDLE, count wait states, access, then one ready cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
`ifdef DMEM_ERR_EN
        err_d   = 1'b0;
`endif
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    size_d  = size;
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ready_d = 1'b1;
`ifdef DMEM_ERR_EN
                err_d   = misaligned;
`endif
                if (!rw_q) begin
                    if (size_q) begin
                        rdata_d = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
                    end else begin
                        rdata_d = {24'd0, mem_q[a0]};
                    end
                end else if (!misaligned) begin
                    mem_we = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and request registers; reset aborts any in-flight access
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'd0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
`ifdef DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
`ifdef DMEM_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Storage array is not reset; stores land big-endian, MSB at the lowest address
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (size_q) begin
                mem_q[a0] <= wdata_q[31:24];
                mem_q[a1] <= wdata_q[23:16];
                mem_q[a2] <= wdata_q[15:8];
                mem_q[a3] <= wdata_q[7:0];
            end else begin
                mem_q[a0] <= wdata_q[7:0];
            end
        end
    end

    assign stall = ((state_q == S_IDLE) && en) || (state_q == S_WAIT) || (state_q == S_ACCESS);
    assign rdata = rdata_q;
    assign ready = ready_q;
`ifdef DMEM_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (WAIT_STATES 2 and 0 instances)
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        R;
    logic        en_v    [2];
    logic        rw_v    [2];
    logic        size_v  [2];
    logic [7:0]  addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic        ready_v [2];
    logic        stall_v [2];
`ifdef DMEM_ERR_EN
    logic        err_v   [2];
`endif

    data_mem_responder #(.WAIT_STATES(2), .DEPTH(256)) dut0 (
        .clk   (clk),
        .R     (R),
        .en    (en_v[0]),
        .rw    (rw_v[0]),
        .size  (size_v[0]),
        .addr  (addr_v[0]),
        .wdata (wdata_v[0]),
        .rdata (rdata_v[0]),
        .ready (ready_v[0]),
        .stall (stall_v[0])
`ifdef DMEM_ERR_EN
        ,
        .err   (err_v[0])
`endif
    );

    data_mem_responder #(.WAIT_STATES(0), .DEPTH(256)) dut1 (
        .clk   (clk),
        .R     (R),
        .en    (en_v[1]),
        .rw    (rw_v[1]),
        .size  (size_v[1]),
        .addr  (addr_v[1]),
        .wdata (wdata_v[1]),
        .rdata (rdata_v[1]),
        .ready (ready_v[1]),
        .stall (stall_v[1])
`ifdef DMEM_ERR_EN
        ,
        .err   (err_v[1])
`endif
    );

    int vec_cnt     = 0;
    int miscompares = 0;

    logic [7:0]  mmem [2][256];
    logic [31:0] mrd  [2];
    logic [31:0] sb_rd  [$];
    logic        sb_err [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Reference model: applies one access to the bench copy of memory and returns expected rdata/err
    task automatic model_apply(input int i, input logic rw, input logic size, input logic [7:0] a,
                               input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_err);
        logic [7:0] b;
        logic [7:0] bk;
        logic       mis;
        b   = a;
        mis = 1'b0;
`ifdef DMEM_ERR_EN
        if (size && (a[1:0] != 2'b00)) begin
            mis = 1'b1;
            b   = a & 8'hFC;
        end
`endif
        if (!rw) begin
            if (size) begin
                for (int k = 0; k < 4; k++) begin
                    bk = b + 8'(k);
                    mrd[i] = {mrd[i][23:0], mmem[i][bk]};
                end
            end else begin
                mrd[i] = {24'd0, mmem[i][b]};
            end
        end else if (!mis) begin
            if (size) begin
                for (int k = 0; k < 4; k++) begin
                    bk = b + 8'(k);
                    mmem[i][bk] = wd[(31 - 8 * k) -: 8];
                end
            end else begin
                mmem[i][b] = wd[7:0];
            end
        end
        exp_rd  = mrd[i];
        exp_err = mis;
    endtask

    // One request on instance i, started at a negedge; returns at the negedge of the following IDLE cycle
    task automatic do_access(input int i, input logic rw, input logic size, input logic [7:0] a,
                             input logic [31:0] wd, input bit hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        bit          seen;
        model_apply(i, rw, size, a, wd, exp_rd, exp_err);
        sb_rd.push_back(exp_rd);
        sb_err.push_back(exp_err);
        en_v[i]    = 1'b1;
        rw_v[i]    = rw;
        size_v[i]  = size;
        addr_v[i]  = a;
        wdata_v[i] = wd;
        #1;
        check("stall_req", 32'(stall_v[i]), 32'd1);
        @(posedge clk);
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (ready_v[i]) begin
                seen = 1'b1;
                check("latency", 32'(n), 32'(ws_of(i) + 2));
                check("stall_done", 32'(stall_v[i]), 32'd0);
                exp_rd  = sb_rd.pop_front();
                exp_err = sb_err.pop_front();
                check("rdata", rdata_v[i], exp_rd);
`ifdef DMEM_ERR_EN
                check("err_done", 32'(err_v[i]), 32'(exp_err));
`endif
                if (!hold) en_v[i] = 1'b0;
            end else begin
                check("stall_busy", 32'(stall_v[i]), 32'd1);
                if (n == 1 && !hold) begin
                    addr_v[i]  = 8'($urandom);
                    wdata_v[i] = $urandom;
                    rw_v[i]    = ~rw;
                    size_v[i]  = ~size;
                end
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("ready_once", 32'(ready_v[i]), 32'd0);
`ifdef DMEM_ERR_EN
        check("err_idle", 32'(err_v[i]), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en_v[i] = 1'b0; rw_v[i] = 1'b0; size_v[i] = 1'b0;
            addr_v[i] = 8'd0; wdata_v[i] = 32'd0; mrd[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_rdata", rdata_v[i], 32'd0);
            check("rst_ready", 32'(ready_v[i]), 32'd0);
            check("rst_stall", 32'(stall_v[i]), 32'd0);
`ifdef DMEM_ERR_EN
            check("rst_err", 32'(err_v[i]), 32'd0);
`endif
        end
        R = 1'b1;
        @(negedge clk);

        // Basic store/load traffic, WAIT_STATES=2
        do_access(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        do_access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
        do_access(0, 1'b0, 1'b0, 8'h12, 32'h0, 1'b0);
        do_access(0, 1'b1, 1'b0, 8'h11, 32'h12345677, 1'b0);
        do_access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);

        // Back-to-back with en held high
        do_access(0, 1'b1, 1'b1, 8'h40, 32'h01020304, 1'b1);
        do_access(0, 1'b0, 1'b1, 8'h40, 32'h0, 1'b1);
        do_access(0, 1'b0, 1'b0, 8'h43, 32'h0, 1'b0);

        // Small randomized region: fill then read back
        for (int k = 0; k < 8; k++) begin
            do_access(0, 1'b1, 1'b1, 8'(8'h80 + 4 * k), $urandom, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            do_access(0, 1'b0, 1'($urandom), 8'(8'h80 + $urandom_range(0, 27)), 32'h0, 1'b0);
        end

        // Reset in the middle of WAIT aborts the store
        do_access(0, 1'b1, 1'b0, 8'h20, 32'h000000A5, 1'b0);
        do_access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
        en_v[0] = 1'b1; rw_v[0] = 1'b1; size_v[0] = 1'b0;
        addr_v[0] = 8'h20; wdata_v[0] = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_wait", 32'(stall_v[0]), 32'd1);
        R = 1'b0;
        en_v[0] = 1'b0;
        #1;
        check("abort_rdata_async", rdata_v[0], 32'd0);
        check("abort_idle_async", 32'(stall_v[0]), 32'd0);
        check("abort_ready", 32'(ready_v[0]), 32'd0);
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        repeat (2) begin
            @(negedge clk);
            check("abort_ready_rst", 32'(ready_v[0]), 32'd0);
        end
        R = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("abort_ready_post", 32'(ready_v[0]), 32'd0);
        end
        do_access(0, 1'b0, 1'b0, 8'h20, 32'h0, 1'b0);
        do_access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);

        // Wrap-around / misalignment on the zero-wait instance
        do_access(1, 1'b1, 1'b1, 8'hFC, 32'h11223344, 1'b0);
        do_access(1, 1'b1, 1'b1, 8'h00, 32'h55667788, 1'b0);
        do_access(1, 1'b1, 1'b1, 8'hFE, 32'hCAFEF00D, 1'b0);
        do_access(1, 1'b0, 1'b1, 8'hFC, 32'h0, 1'b0);
        do_access(1, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0);
        do_access(1, 1'b0, 1'b0, 8'hFF, 32'h0, 1'b0);
        do_access(1, 1'b0, 1'b0, 8'h01, 32'h0, 1'b0);
        do_access(1, 1'b0, 1'b1, 8'hFE, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
